// File: rtl/csa_stream_accum_pkg.sv
// Shared types and width helpers for the carry-save streaming accumulator.
package csa_stream_accum_pkg;

  typedef enum logic [1:0] {
    ST_ACC     = 2'd0,
    ST_RESOLVE = 2'd1,
    ST_OUT     = 2'd2
  } state_e;

  function automatic int unsigned out_w_f(input int unsigned width, input int unsigned max_ops);
    return width + $clog2(max_ops);
  endfunction

  function automatic int unsigned cnt_w_f(input int unsigned max_ops);
    return $clog2(max_ops + 1);
  endfunction

endpackage

// File: rtl/csa_3to2_row.sv
// One row of W independent full adders (3:2 compressor); carry alignment is left to the caller.
module csa_3to2_row #(
  parameter int unsigned W = 6
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] s_o,
  output logic [W-1:0] c_o
);

  always_comb begin
    s_o = a_i ^ b_i ^ d_i;
    c_o = (a_i & b_i) | (a_i & d_i) | (b_i & d_i);
  end

endmodule

// File: rtl/csa_stream_accum.sv
// Streaming multi-operand adder: carry-save accumulation per beat, one resolve add per frame.
// Optional threshold compare outputs when CSA_STREAM_ACCUM_THRESH_EN is defined.
module csa_stream_accum
  import csa_stream_accum_pkg::*;
#(
  parameter  int unsigned WIDTH   = 4,
  parameter  int unsigned MAX_OPS = 4,
  localparam int unsigned OUT_W   = out_w_f(WIDTH, MAX_OPS),
  localparam int unsigned CNT_W   = cnt_w_f(MAX_OPS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_sum,
  output logic [CNT_W-1:0] out_count,
`ifdef CSA_STREAM_ACCUM_THRESH_EN
  input  logic [OUT_W-1:0] thr,
  output logic             out_gt,
  output logic             out_lt,
  output logic             out_eq,
`endif
  output logic             out_ovf
);

  state_e           state_q, state_d;
  logic [OUT_W-1:0] s_q, s_d, c_q, c_d, sum_q, sum_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d, valid_q, valid_d;
  logic [OUT_W-1:0] c_al, din_ext, row_s, row_c, resolved;
  logic             beat, hshake;

  // Carries are stored unshifted; the shift drops bit OUT_W-1, giving modulo-2^OUT_W sums.
  assign c_al     = c_q << 1;
  assign din_ext  = OUT_W'(in_data);
  assign resolved = s_q + c_al;

  csa_3to2_row #(.W(OUT_W)) u_row (
    .a_i(s_q),
    .b_i(c_al),
    .d_i(din_ext),
    .s_o(row_s),
    .c_o(row_c)
  );

  assign in_ready  = (state_q == ST_ACC);
  assign beat      = in_valid && in_ready;
  assign hshake    = (state_q == ST_OUT) && valid_q && out_ready;
  assign out_valid = valid_q;
  assign out_sum   = sum_q;
  assign out_count = cnt_q;
  assign out_ovf   = ovf_q;

`ifdef CSA_STREAM_ACCUM_THRESH_EN
  logic gt_q, gt_d, lt_q, lt_d, eq_q, eq_d;
  assign out_gt = gt_q;
  assign out_lt = lt_q;
  assign out_eq = eq_q;
`endif

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    c_d     = c_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    sum_d   = sum_q;
    valid_d = valid_q;
`ifdef CSA_STREAM_ACCUM_THRESH_EN
    gt_d = gt_q;
    lt_d = lt_q;
    eq_d = eq_q;
`endif
    unique case (state_q)
      ST_ACC: begin
        if (beat) begin
          s_d = row_s;
          c_d = row_c;
          if (cnt_q == CNT_W'(MAX_OPS)) ovf_d = 1'b1;
          else                          cnt_d = cnt_q + CNT_W'(1);
          if (in_last) state_d = ST_RESOLVE;
        end
      end
      ST_RESOLVE: begin
        sum_d   = resolved;
        state_d = ST_OUT;
`ifdef CSA_STREAM_ACCUM_THRESH_EN
        gt_d = (resolved > thr);
        lt_d = (resolved < thr);
        eq_d = (resolved == thr);
`endif
      end
      ST_OUT: begin
        // Valid is registered one cycle into OUT so it rises two edges after the last beat.
        valid_d = 1'b1;
        if (hshake) begin
          valid_d = 1'b0;
          s_d     = '0;
          c_d     = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
          state_d = ST_ACC;
`ifdef CSA_STREAM_ACCUM_THRESH_EN
          gt_d = 1'b0;
          lt_d = 1'b0;
          eq_d = 1'b0;
`endif
        end
      end
      default: state_d = ST_ACC;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_ACC;
      s_q     <= '0;
      c_q     <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      sum_q   <= '0;
      valid_q <= 1'b0;
`ifdef CSA_STREAM_ACCUM_THRESH_EN
      gt_q <= 1'b0;
      lt_q <= 1'b0;
      eq_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      c_q     <= c_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      sum_q   <= sum_d;
      valid_q <= valid_d;
`ifdef CSA_STREAM_ACCUM_THRESH_EN
      gt_q <= gt_d;
      lt_q <= lt_d;
      eq_q <= eq_d;
`endif
    end
  end

endmodule
